seg7_scan_driver: RTL

//  Time-multiplexed 4-digit hex 7-segment driver; directly downstream of the 16-bit adder top.

---
 rtl/seg7_scan_driver.sv | 101 ++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit hex 7-segment driver with per-frame value capture.
// Optional SEG7_LZ_BLANK_EN: blank leading zero digits (digit0 always shown).
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] input_value,
  output logic [3:0]  disp_en,
  output logic [6:0]  seg7_output,
  output logic        frame_pulse
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [3:0] EN_OFF  = ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [CW-1:0] presc;
  logic          tick;
  logic [1:0]    digit_idx, idx_nxt;
  logic [15:0]   shadow, shadow_nxt;
  logic [3:0]    nibble;
  logic          blank;
  logic [3:0]    en_l;
  logic [6:0]    seg_l;

  // Segment patterns are active-low, {g,f,e,d,c,b,a}
  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  assign tick = (presc == CW'(REFRESH_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) presc <= '0;
    else             presc <= presc + CW'(1);
  end

  always_comb begin
    idx_nxt    = digit_idx;
    shadow_nxt = shadow;
    if (tick) begin
      idx_nxt = digit_idx + 2'd1;
      if (digit_idx == 2'd3) shadow_nxt = input_value;
    end
  end

  // Output stage looks at the values being loaded this edge so pins follow tick by one clock
  always_comb begin
    case (idx_nxt)
      2'd0:    nibble = shadow_nxt[3:0];
      2'd1:    nibble = shadow_nxt[7:4];
      2'd2:    nibble = shadow_nxt[11:8];
      default: nibble = shadow_nxt[15:12];
    endcase
`ifdef SEG7_LZ_BLANK_EN
    blank = (idx_nxt != 2'd0) && ((shadow_nxt >> {idx_nxt, 2'b00}) == 16'h0000);
`else
    blank = 1'b0;
`endif
    en_l  = blank ? 4'hF  : ~(4'b0001 << idx_nxt);
    seg_l = blank ? 7'h7F : decode(nibble);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digit_idx   <= 2'd3;
      shadow      <= 16'h0000;
      frame_pulse <= 1'b0;
      disp_en     <= EN_OFF;
      seg7_output <= SEG_OFF;
    end else begin
      digit_idx   <= idx_nxt;
      shadow      <= shadow_nxt;
      frame_pulse <= tick && (digit_idx == 2'd3);
      if (tick) begin
        disp_en     <= ACTIVE_LOW ? en_l  : ~en_l;
        seg7_output <= ACTIVE_LOW ? seg_l : ~seg_l;
      end
    end
  end

endmodule
